// File: rtl/alu_md_control.sv
// ALU operation decoder plus an iterative RV32M/RV64M multiply/divide sequencer.
// The sequencer stalls the pipeline via o_busy and pulses o_done when o_md_result is valid.
module alu_md_control #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   input  logic [6:0]      i_opcode,
   input  logic [6:0]      i_funct7,
   input  logic [2:0]      i_funct3,
   input  logic [2:0]      i_aluop,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic [3:0]      o_alu_operation,
   output logic            o_md_sel,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_md_result
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT = 7'h20;
   localparam logic [6:0] F7_M = 7'h01;
   localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [XLEN-1:0]   hi_r, lo_r, opnd_r;
   logic [2:0]        f3_r;
   logic              neg_r, rneg_r;

   logic              md_op, start, alt;
   logic [3:0]        alu_op;
   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, div_ovf, fast;
   logic [XLEN-1:0]   fast_res;
   logic [XLEN:0]     mul_sum, div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   nhi, nlo, quo_fix, rem_fix, md_res;
   logic [2*XLEN-1:0] prod, prod_fix;

   // ALU operation decode from the main-control class and instruction fields
   always_comb begin
      alu_op = 4'h0;
      alt = (i_funct7 == F7_ALT);
      if (i_aluop == 3'd1) begin
         alu_op = 4'h1;
      end else if (i_aluop == 3'd2 && i_opcode == OP_R) begin
         if (i_funct7 == F7_M) begin
            alu_op = 4'h2;
         end else if (i_funct7 == F7_BASE || alt) begin
            case (i_funct3)
               3'd0:    alu_op = alt ? 4'h1 : 4'h0;
               3'd1:    alu_op = 4'h3;
               3'd2:    alu_op = 4'h4;
               3'd3:    alu_op = 4'h4;
               3'd4:    alu_op = 4'h5;
               3'd5:    alu_op = alt ? 4'hB : 4'h6;
               3'd6:    alu_op = 4'h7;
               3'd7:    alu_op = 4'h8;
               default: alu_op = 4'h0;
            endcase
         end else begin
            alu_op = 4'h0;
         end
      end else if (i_aluop == 3'd2 && i_opcode == OP_I) begin
         case (i_funct3)
            3'd0:    alu_op = 4'h0;
            3'd1:    alu_op = 4'h9;
            3'd2:    alu_op = 4'h4;
            3'd3:    alu_op = 4'h4;
            3'd4:    alu_op = 4'h5;
            3'd5:    alu_op = alt ? 4'hC : 4'hA;
            3'd6:    alu_op = 4'h7;
            3'd7:    alu_op = 4'h8;
            default: alu_op = 4'h0;
         endcase
      end else begin
         alu_op = 4'h0;
      end
   end

   assign md_op = (i_aluop == 3'd2) && (i_opcode == OP_R) && (i_funct7 == F7_M);
   assign start = i_valid && md_op && (state == S_IDLE) && !i_rst;
   assign o_busy = !i_rst && (start || state == S_CALC);
   assign o_md_sel = md_op;
   assign o_alu_operation = alu_op;

   // Operand magnitudes, sign flags and fast-path detection for the start cycle
   always_comb begin
      a_signed = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                 (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
      b_signed = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) ||
                 (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
      a_neg = a_signed && i_rs1[XLEN-1];
      b_neg = b_signed && i_rs2[XLEN-1];
      a_mag = a_neg ? (~i_rs1 + ONE_X) : i_rs1;
      b_mag = b_neg ? (~i_rs2 + ONE_X) : i_rs2;
      div_zero = i_funct3[2] && (i_rs2 == ZERO_X);
      div_ovf = i_funct3[2] && !i_funct3[0] && (i_rs1 == MIN_X) && (i_rs2 == ONES_X);
      fast = div_zero || div_ovf;
      if (div_zero) begin
         fast_res = i_funct3[1] ? i_rs1 : ONES_X;
      end else begin
         fast_res = i_funct3[1] ? ZERO_X : i_rs1;
      end
   end

   // One radix-2 step: shift-add multiply or restoring divide, then sign fix-up
   always_comb begin
      mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_X});
      div_shift = {hi_r, lo_r[XLEN-1]};
      div_ge = (div_shift >= {1'b0, opnd_r});
      if (f3_r[2]) begin
         nhi = div_ge ? (div_shift[XLEN-1:0] - opnd_r) : div_shift[XLEN-1:0];
         nlo = {lo_r[XLEN-2:0], div_ge};
      end else begin
         nhi = mul_sum[XLEN:1];
         nlo = {mul_sum[0], lo_r[XLEN-1:1]};
      end
      prod = {nhi, nlo};
      prod_fix = neg_r ? (~prod + ONE_2X) : prod;
      quo_fix = neg_r ? (~nlo + ONE_X) : nlo;
      rem_fix = rneg_r ? (~nhi + ONE_X) : nhi;
      case (f3_r)
         3'd0:    md_res = prod_fix[XLEN-1:0];
         3'd1:    md_res = prod_fix[2*XLEN-1:XLEN];
         3'd2:    md_res = prod_fix[2*XLEN-1:XLEN];
         3'd3:    md_res = prod_fix[2*XLEN-1:XLEN];
         3'd4:    md_res = quo_fix;
         3'd5:    md_res = quo_fix;
         3'd6:    md_res = rem_fix;
         3'd7:    md_res = rem_fix;
         default: md_res = ZERO_X;
      endcase
   end

   // Sequencer FSM with registered result and done pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_IDLE;
         cnt         <= {CW{1'b0}};
         hi_r        <= ZERO_X;
         lo_r        <= ZERO_X;
         opnd_r      <= ZERO_X;
         f3_r        <= 3'd0;
         neg_r       <= 1'b0;
         rneg_r      <= 1'b0;
         o_md_result <= ZERO_X;
         o_done      <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  f3_r   <= i_funct3;
                  neg_r  <= a_neg ^ b_neg;
                  rneg_r <= a_neg;
                  hi_r   <= ZERO_X;
                  cnt    <= CW'(XLEN);
                  if (fast) begin
                     o_md_result <= fast_res;
                     o_done      <= 1'b1;
                     state       <= S_DONE;
                  end else begin
                     // divide: opnd = divisor, lo = dividend; multiply: opnd = multiplicand
                     opnd_r <= i_funct3[2] ? b_mag : a_mag;
                     lo_r   <= i_funct3[2] ? a_mag : b_mag;
                     state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               hi_r <= nhi;
               lo_r <= nlo;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  o_md_result <= md_res;
                  o_done      <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
